timed_block_memory: RTL
=======================

# timed_block_memory

Clocked main-memory responder at the far end of the cache-to-memory block interface. Accepts one block-read or block-write request at a time from the cache controller and services it after a fixed, parameterised latency. Signals completion with a one-cycle `ready` pulse. Holds 1 KiB as 64 blocks of 128 bits, addressed by the same 10-bit byte address the CPU drives.

## Interface
- `LATENCY`, 4, cycles from request acceptance to `ready`; legal range 1..15.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid; sampled only when `busy`=0.
- `read_write`  in  1  0 = block read, 1 = block write; sampled with `req`.
- `address`  in  10  byte address; block index = `address[9:4]`; `address[3:0]` ignored.
- `writeData`  in  128  write block; word k occupies bits [32k+31:32k], k=0..3.
- `readData`  out  128  last block read; same word packing as `writeData`.
- `ready`  out  1  one-cycle completion pulse for both reads and writes.
- `busy`  out  1  high while a request is in flight.

## Operation
- Storage: 64 x 128-bit array `blk[0..63]`, registered.
- Reset contents: word w (w = 0..255, block w/4, word w%4) = {22'b0, w, 2'b00}. Each word holds its own byte address.
- FSM states: IDLE (`busy`=0) and BUSY (`busy`=1). A down-counter `cnt` of 4 bits runs during BUSY.
- IDLE behaviour, when `req`=1 at an edge:
  - latch `read_write`, `address[9:4]` and `writeData` into internal registers;
  - load `cnt` = LATENCY-1;
  - go to BUSY.
- IDLE behaviour, when `req`=0: stay in IDLE.
- BUSY behaviour, when `cnt`≠0: decrement `cnt`.
- BUSY behaviour, when `cnt`=0, complete the access:
  - for a read, `readData` <= `blk[idx]`;
  - for a write, `blk[idx]` <= latched data;
  - assert `ready` for one cycle and return to IDLE.
- Inputs seen while BUSY, including `req`, `address` and `writeData` changes, are ignored. All accesses use the latched copies.
- `readData` changes only when a read completes. A completed write leaves `readData` unchanged.
- A write affects only the addressed block. The other 63 blocks are untouched.
- Reset at any time, including mid-transaction:
  - return to IDLE;
  - `ready`=0, `busy`=0, `readData`=0;
  - restore the reset contents;
  - the in-flight write is discarded and no pulse is issued.
- Reset has priority over `req` in the same cycle.

## Timing
- Reset values: `ready`=0, `busy`=0, `readData`=128'b0.
- Request accepted at edge E0 (`busy`=0, `req`=1).
- `busy`=1 from after E0 through to edge E0+LATENCY.
- After edge E0+LATENCY:
  - `ready`=1 for exactly one cycle;
  - `busy`=0;
  - `readData` is valid for a read.
- `ready` and `busy` are never both 1.
- At edge E0+LATENCY a new `req` is not accepted, because `busy` was still 1 before that edge.
- The earliest next acceptance is edge E0+LATENCY+1. Sustained throughput is one transaction per LATENCY+1 cycles.
- With LATENCY=1: accept at E0, complete at E0+1.
- A held `req`=1 re-issues the same request at every acceptance opportunity. The requester must drop `req` on seeing `ready` if it wants a single transaction.

## Test plan
- Reset then read, `address`=10'h3F4 (block 63), LATENCY=4 -> `ready` 4 cycles after acceptance; `readData` = {32'h3FC, 32'h3F8, 32'h3F4, 32'h3F0}.
- Write `address`=10'h048, `writeData`={32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA} -> `ready` pulse with `readData` unchanged. A following read of 10'h040 -> that same 128-bit value. A read of block 3 still returns its reset contents.
- Accept a read of block 1; toggle `req`/`address` to block 5 every cycle while `busy`=1 -> exactly one `ready`, returning block 1 contents; next acceptance no earlier than E0+5.
- Start a write to block 2; assert `reset` two cycles after acceptance -> no `ready`; `busy`=0 and `readData`=0 after reset; a read of block 2 returns reset contents {32'h2C, 32'h28, 32'h24, 32'h20}.
- Hold `req`=1, read, block 0, for 12 cycles with LATENCY=4 -> `ready` pulses at E0+4 and E0+9; `ready` is never high on two consecutive cycles.
- Instantiate with LATENCY=1: read block 10 -> `ready` one cycle after acceptance; `readData` = {32'hAC, 32'hA8, 32'hA4, 32'hA0}.

Source files
------------

// File: rtl/timed_block_memory.sv
// timed_block_memory: main-memory responder for the cache block interface.
// Holds 64 blocks of 128 bits and services one block read or block write at
// a time, finishing LATENCY cycles after acceptance with a one-cycle ready.

module timed_block_memory #(
  parameter int LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         read_write,
  input  logic [9:0]   address,
  input  logic [127:0] writeData,
  output logic [127:0] readData,
  output logic         ready,
  output logic         busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rw_q, rw_d;
  logic [5:0]   idx_q, idx_d;
  logic [127:0] wdata_q, wdata_d;
  logic [127:0] read_data_q, read_data_d;
  logic         ready_q, ready_d;
  logic [127:0] mem_q [64];
  logic [127:0] mem_d [64];
  logic         accept;
  logic         complete;

  // The low nibble selects a byte within a block and is irrelevant here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[3:0];

  // Power-up image of a block: every word holds its own byte address.
  function automatic logic [127:0] init_block(input logic [5:0] blk);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[32*k +: 32] = {22'b0, blk, 2'(k), 2'b00};
    end
    return r;
  endfunction

  // State register plus all datapath flops; reset restores the memory image.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      for (int b = 0; b < 64; b++) begin
        mem_q[b] <= init_block(6'(b));
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      mem_q       <= mem_d;
    end
  end

  // Next state: leave IDLE on an accepted request, return when the count expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag, request acceptance and access completion strobes.
  always_comb begin
    busy     = (state_q == BUSY);
    accept   = (state_q == IDLE) && req;
    complete = (state_q == BUSY) && (cnt_q == 4'd0);
  end

  // Datapath: latch the request on acceptance, count down, perform the access at the end.
  always_comb begin
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    ready_d     = complete;
    mem_d       = mem_q;
    if (accept) begin
      cnt_d   = 4'(LATENCY - 1);
      rw_d    = read_write;
      idx_d   = address[9:4];
      wdata_d = writeData;
    end else if (busy && !complete) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (complete) begin
      if (rw_q) begin
        mem_d[idx_q] = wdata_q;
      end else begin
        read_data_d = mem_q[idx_q];
      end
    end
  end

  assign readData = read_data_q;
  assign ready    = ready_q;

endmodule
